ram_wb_target: RTL and testbench



---
 rtl/ram_wb_target.sv | 166 ++++++++++++++++
 tb/tb_ram_wb_target.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wb_target.sv
// Wishbone B4 pipelined target that sequences an external asynchronous SRAM.
// Strobe widths are derived from nanosecond parameters at the 64 MHz clock.
module ram_wb_target #(
  parameter logic [2:0]  BASE    = 3'b000,
  parameter int unsigned READ_NS = 55,
  parameter int unsigned WE_NS   = 45
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [19:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [16:0] ram_addr_o,
  input  logic [7:0]  ram_data_i,
  output logic [7:0]  ram_data_o,
  output logic        ram_data_oe_o,
  output logic        ram_ce_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o
);

  localparam int unsigned CLK_MHZ = 64;

  // Round a nanosecond figure up to whole system-clock cycles.
  function automatic int unsigned ns_to_cycles(input int unsigned ns);
    return (ns * CLK_MHZ + 999) / 1000;
  endfunction

  localparam int unsigned READ_CYCLES = ns_to_cycles(READ_NS);
  localparam int unsigned WE_CYCLES   = ns_to_cycles(WE_NS);
  localparam int unsigned MAX_CYCLES  = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
  localparam int unsigned CNT_W       = $clog2(MAX_CYCLES + 1);

  // Timing parameters must yield at least one cycle per strobe.
  if (READ_CYCLES < 1 || WE_CYCLES < 1) begin : g_bad_timing
    $error("ram_wb_target: READ_CYCLES and WE_CYCLES must both be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         dat_d;
  logic               ack_d;
  logic [16:0]        addr_d;
  logic [7:0]         wdata_d;
  logic               data_oe_d;
  logic               ce_n_d, oe_n_d, we_n_d;
  logic               sel;

  assign sel = wb_cyc_i & wb_stb_i & (wb_adr_i[19:17] == BASE);

  // Busy whenever an SRAM sequence is in flight, regardless of who is asking.
  assign wb_stall_o = (state_q != IDLE);

  // Next-state and next-output logic for the SRAM strobe sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dat_d     = wb_dat_o;
    ack_d     = 1'b0;
    addr_d    = ram_addr_o;
    wdata_d   = ram_data_o;
    data_oe_d = ram_data_oe_o;
    ce_n_d    = ram_ce_n_o;
    oe_n_d    = ram_oe_n_o;
    we_n_d    = ram_we_n_o;

    case (state_q)
      IDLE: begin
        if (sel) begin
          addr_d = wb_adr_i[16:0];
          ce_n_d = 1'b0;
          if (wb_we_i) begin
            wdata_d   = wb_dat_i;
            data_oe_d = 1'b1;
            we_n_d    = 1'b1;
            state_d   = WR_SETUP;
          end else begin
            oe_n_d  = 1'b0;
            cnt_d   = CNT_W'(READ_CYCLES - 1);
            state_d = READ;
          end
        end
      end

      READ: begin
        if (cnt_q == '0) begin
          dat_d   = ram_data_i;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ack_d   = wb_cyc_i;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = CNT_W'(WE_CYCLES - 1);
        state_d = WR_PULSE;
      end

      // The write pulse always runs to full width, even if the initiator left.
      WR_PULSE: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      WR_HOLD: begin
        data_oe_d = 1'b0;
        ce_n_d    = 1'b1;
        ack_d     = wb_cyc_i;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset returns the SRAM to a quiet bus.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wb_dat_o      <= '0;
      wb_ack_o      <= 1'b0;
      ram_addr_o    <= '0;
      ram_data_o    <= '0;
      ram_data_oe_o <= 1'b0;
      ram_ce_n_o    <= 1'b1;
      ram_oe_n_o    <= 1'b1;
      ram_we_n_o    <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_dat_o      <= dat_d;
      wb_ack_o      <= ack_d;
      ram_addr_o    <= addr_d;
      ram_data_o    <= wdata_d;
      ram_data_oe_o <= data_oe_d;
      ram_ce_n_o    <= ce_n_d;
      ram_oe_n_o    <= oe_n_d;
      ram_we_n_o    <= we_n_d;
    end
  end

endmodule

// File: tb/tb_ram_wb_target.sv
// Directed bench for ram_wb_target with a behavioural SRAM and bus-protocol checks.
module tb_ram_wb_target;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [19:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic [16:0] ram_addr_o;
  logic [7:0]  ram_data_i;
  logic [7:0]  ram_data_o;
  logic        ram_data_oe_o;
  logic        ram_ce_n_o;
  logic        ram_oe_n_o;
  logic        ram_we_n_o;

  logic [7:0]  mem [0:131071];
  int          checks = 0;
  int          errors = 0;
  logic        prev_ack = 1'b0;
  logic        prev_we_n = 1'b1;

  ram_wb_target dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_we_i      (wb_we_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_stall_o   (wb_stall_o),
    .wb_ack_o     (wb_ack_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_i   (ram_data_i),
    .ram_data_o   (ram_data_o),
    .ram_data_oe_o(ram_data_oe_o),
    .ram_ce_n_o   (ram_ce_n_o),
    .ram_oe_n_o   (ram_oe_n_o),
    .ram_we_n_o   (ram_we_n_o)
  );

  always #8 clk_i = ~clk_i;

  // Asynchronous SRAM read path.
  assign ram_data_i = (ram_ce_n_o === 1'b0 && ram_oe_n_o === 1'b0) ? mem[ram_addr_o] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; run protocol checks and the SRAM write model.
  task automatic tick();
    @(negedge clk_i);
    chk("oe_we_overlap", 32'(ram_oe_n_o === 1'b0 && ram_we_n_o === 1'b0), 32'd0);
    chk("drive_during_oe", 32'(ram_data_oe_o === 1'b1 && ram_oe_n_o === 1'b0), 32'd0);
    chk("ack_width", 32'(prev_ack === 1'b1 && wb_ack_o === 1'b1), 32'd0);
    prev_ack = wb_ack_o;
    if (prev_we_n === 1'b0 && ram_we_n_o === 1'b1 && ram_ce_n_o === 1'b0)
      mem[ram_addr_o] = ram_data_o;
    prev_we_n = ram_we_n_o;
  endtask

  // One request, cycle held until ack; edge index 0 is the accept edge.
  task automatic run_op(input logic we, input logic [19:0] adr, input logic [7:0] d,
                        output int ack_edge, output int oe_low, output int we_low,
                        output int we_first, output int stall_hi, output int bad,
                        output logic [7:0] rd);
    ack_edge = -1; oe_low = 0; we_low = 0; we_first = -1; stall_hi = 0; bad = 0; rd = 8'h00;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = d;
    for (int k = 0; k < 20 && ack_edge < 0; k++) begin
      tick();
      if (k == 0) wb_stb_i = 1'b0;
      if (ram_oe_n_o === 1'b0) oe_low++;
      if (ram_we_n_o === 1'b0) begin
        we_low++;
        if (we_first < 0) we_first = k;
      end
      if (wb_stall_o === 1'b1) stall_hi++;
      if (ram_ce_n_o === 1'b0 && (ram_addr_o !== adr[16:0] || (we && ram_data_o !== d))) bad++;
      if (wb_ack_o === 1'b1) begin
        ack_edge = k;
        rd = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0;
  endtask

  initial begin
    int ack_e, oe_l, we_l, we_f, st_h, bad, cnt_a, cnt_ce, cnt_st, edge_n, ack1, acc2, ack2;
    logic [7:0] rd;

    reset_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    mem[17'h1A234] = 8'hA5;
    tick(); tick();

    // Reset state
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_stall", 32'(wb_stall_o), 32'd0);
    chk("rst_dat", 32'(wb_dat_o), 32'd0);
    chk("rst_addr", 32'(ram_addr_o), 32'd0);
    chk("rst_wdata", 32'(ram_data_o), 32'd0);
    chk("rst_data_oe", 32'(ram_data_oe_o), 32'd0);
    chk("rst_strobes", 32'({ram_ce_n_o, ram_oe_n_o, ram_we_n_o}), 32'h7);
    reset_i = 1'b0;
    tick(); tick();

    // Read 0x1A234 -> 0xA5
    run_op(1'b0, 20'h1A234, 8'h00, ack_e, oe_l, we_l, we_f, st_h, bad, rd);
    chk("rd_ack_edge", 32'(ack_e), 32'd4);
    chk("rd_oe_low", 32'(oe_l), 32'd4);
    chk("rd_stall_hi", 32'(st_h), 32'd4);
    chk("rd_addr_bad", 32'(bad), 32'd0);
    chk("rd_data", 32'(rd), 32'hA5);
    chk("rd_we_low", 32'(we_l), 32'd0);
    tick();
    chk("rd_ack_drop", 32'(wb_ack_o), 32'd0);

    // Write 0x3C -> 0x00010
    run_op(1'b1, 20'h00010, 8'h3C, ack_e, oe_l, we_l, we_f, st_h, bad, rd);
    chk("wr_ack_edge", 32'(ack_e), 32'd5);
    chk("wr_we_low", 32'(we_l), 32'd3);
    chk("wr_we_first", 32'(we_f), 32'd1);
    chk("wr_oe_low", 32'(oe_l), 32'd0);
    chk("wr_stable_bad", 32'(bad), 32'd0);
    chk("wr_stall_hi", 32'(st_h), 32'd5);
    chk("wr_mem", 32'(mem[17'h00010]), 32'h3C);
    tick();
    chk("wr_idle_strobes", 32'({ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_data_oe_o}), 32'hE);

    // Back-to-back: write 0x55 to 0x00001 then read it with stb held.
    // Write acks after edge 5; the read is taken on edge 6 (ack cycle) and acks 4 edges later.
    ack1 = -1; acc2 = -1; ack2 = -1; rd = 8'h00;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 20'h00001; wb_dat_i = 8'h55;
    for (edge_n = 0; edge_n < 20 && ack2 < 0; edge_n++) begin
      tick();
      if (ack1 >= 0 && acc2 < 0 && ram_oe_n_o === 1'b0) begin
        acc2 = edge_n;
        wb_stb_i = 1'b0;
      end
      if (wb_ack_o === 1'b1) begin
        if (ack1 < 0) begin
          ack1 = edge_n;
          wb_we_i = 1'b0;
        end else begin
          ack2 = edge_n;
          rd = wb_dat_o;
        end
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("b2b_wr_ack", 32'(ack1), 32'd5);
    chk("b2b_rd_accept", 32'(acc2), 32'd6);
    chk("b2b_rd_ack", 32'(ack2), 32'd10);
    chk("b2b_rd_data", 32'(rd), 32'h55);
    tick();

    // Decode miss: 0x20000 is outside BASE 0
    cnt_a = 0; cnt_ce = 0; cnt_st = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 20'h20000; wb_dat_i = 8'hEE;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (wb_ack_o === 1'b1) cnt_a++;
      if (ram_ce_n_o !== 1'b1 || ram_we_n_o !== 1'b1 || ram_oe_n_o !== 1'b1) cnt_ce++;
      if (wb_stall_o === 1'b1) cnt_st++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("miss_ack", 32'(cnt_a), 32'd0);
    chk("miss_sram", 32'(cnt_ce), 32'd0);
    chk("miss_stall", 32'(cnt_st), 32'd0);

    // Abort: cycle dropped one cycle into a write 0x77 -> 0x00100
    cnt_a = 0; we_l = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 20'h00100; wb_dat_i = 8'h77;
    tick();
    chk("abort_accept", 32'(wb_stall_o), 32'd1);
    wb_stb_i = 1'b0;
    tick();
    if (ram_we_n_o === 1'b0) we_l++;
    wb_cyc_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ram_we_n_o === 1'b0) we_l++;
      if (wb_ack_o === 1'b1) cnt_a++;
    end
    chk("abort_we_low", 32'(we_l), 32'd3);
    chk("abort_ack", 32'(cnt_a), 32'd0);
    chk("abort_mem", 32'(mem[17'h00100]), 32'h77);
    chk("abort_idle", 32'(wb_stall_o), 32'd0);

    // Asynchronous reset in the middle of a read, between clock edges
    cnt_a = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 20'h1A234;
    tick();
    wb_stb_i = 1'b0;
    tick();
    chk("pre_rst_oe_low", 32'(ram_oe_n_o), 32'd0);
    #3 reset_i = 1'b1;
    #1;
    chk("mid_rst_strobes", 32'({ram_ce_n_o, ram_oe_n_o, ram_we_n_o}), 32'h7);
    chk("mid_rst_data_oe", 32'(ram_data_oe_o), 32'd0);
    chk("mid_rst_ack", 32'(wb_ack_o), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr_o), 32'd0);
    tick();
    reset_i = 1'b0;
    chk("post_rst_stall", 32'(wb_stall_o), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (wb_ack_o === 1'b1) cnt_a++;
    end
    wb_cyc_i = 1'b0;
    chk("post_rst_no_ack", 32'(cnt_a), 32'd0);
    chk("post_rst_strobes", 32'({ram_ce_n_o, ram_oe_n_o, ram_we_n_o}), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
